// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder held in a single registered pipeline slot.
// Optional macro DECODE_ILLEGAL_EN: drive illegal=1 for undecodable words.
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif
`ifndef ALU_OP_BITS
`define ALU_OP_BITS 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SHL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SHR  4'd6
`define ALU_SHA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_SRC2 4'd10
`endif

module decode_stage #(
    parameter int OP_SIZE = `DWORD_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             instr,
    input  logic [OP_SIZE-1:0]      pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [`ALU_OP_BITS-1:0] alu_op,
    output logic                    src1_sel,
    output logic                    src2_sel,
    output logic [OP_SIZE-1:0]      imm,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    output logic [4:0]              rd,
    output logic                    reg_write,
    output logic                    is_branch,
    output logic                    illegal,
    output logic [OP_SIZE-1:0]      pc_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_FLAG = 1'b1;
`else
    localparam logic ILL_FLAG = 1'b0;
`endif

    typedef logic [`ALU_OP_BITS-1:0] alu_t;

    typedef struct packed {
        alu_t               alu_op;
        logic               src1_sel;
        logic               src2_sel;
        logic [OP_SIZE-1:0] imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               reg_write;
        logic               is_branch;
        logic               illegal;
        logic [OP_SIZE-1:0] pc;
    } bundle_t;

    function automatic alu_t f3_alu(input logic [2:0] f3);
        alu_t r;
        unique case (f3)
            3'b000:  r = `ALU_ADD;
            3'b001:  r = `ALU_SHL;
            3'b010:  r = `ALU_SLT;
            3'b011:  r = `ALU_SLTU;
            3'b100:  r = `ALU_XOR;
            3'b101:  r = `ALU_SHR;
            3'b110:  r = `ALU_OR;
            default: r = `ALU_AND;
        endcase
        return r;
    endfunction

    function automatic bundle_t reset_bundle();
        bundle_t b;
        b        = '0;
        b.alu_op = `ALU_ADD;
        return b;
    endfunction

    logic [6:0]         opcode;
    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic               is_op, is_imm, is_lui, is_auipc, is_load;
    logic               is_store, is_br, is_jal, is_jalr;
    logic [OP_SIZE-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    alu_t               dec_alu;
    logic               dec_s1, dec_s2, dec_wr, dec_br, dec_ok;
    logic [OP_SIZE-1:0] dec_imm;
    bundle_t            dec_b;

    logic               valid_q, valid_d;
    bundle_t            bundle_q, bundle_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_IMM);
    assign is_lui   = (opcode == OPC_LUI);
    assign is_auipc = (opcode == OPC_AUIPC);
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign is_br    = (opcode == OPC_BRANCH);
    assign is_jal   = (opcode == OPC_JAL);
    assign is_jalr  = (opcode == OPC_JALR);

    // Shift-immediates carry only the shamt; funct7 is opcode space.
    assign imm_i  = OP_SIZE'($signed(instr[31:20]));
    assign imm_s  = OP_SIZE'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = OP_SIZE'($signed({instr[31], instr[7], instr[30:25],
                                      instr[11:8], 1'b0}));
    assign imm_u  = OP_SIZE'($signed({instr[31:12], 12'b0}));
    assign imm_j  = OP_SIZE'($signed({instr[31], instr[19:12], instr[20],
                                      instr[30:21], 1'b0}));
    assign imm_sh = OP_SIZE'(instr[24:20]);

    // Opcode/funct decode into control fields plus a legality flag.
    always_comb begin
        dec_alu = `ALU_ADD;
        dec_s1  = 1'b0;
        dec_s2  = 1'b0;
        dec_wr  = 1'b0;
        dec_br  = 1'b0;
        dec_ok  = 1'b0;
        dec_imm = '0;
        unique case (1'b1)
            is_op: begin
                dec_wr = 1'b1;
                if (funct7 == F7_ZERO) begin
                    dec_ok  = 1'b1;
                    dec_alu = f3_alu(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_ok  = 1'b1;
                    dec_alu = `ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_ok  = 1'b1;
                    dec_alu = `ALU_SHA;
                end
            end
            is_imm: begin
                dec_wr  = 1'b1;
                dec_s2  = 1'b1;
                dec_imm = imm_i;
                dec_alu = f3_alu(funct3);
                dec_ok  = 1'b1;
                if (funct3 == 3'b001) begin
                    dec_imm = imm_sh;
                    dec_ok  = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    dec_imm = imm_sh;
                    dec_ok  = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    if (funct7 == F7_ALT) begin
                        dec_alu = `ALU_SHA;
                    end
                end
            end
            is_lui: begin
                dec_ok  = 1'b1;
                dec_alu = `ALU_SRC2;
                dec_s2  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_u;
            end
            is_auipc: begin
                dec_ok  = 1'b1;
                dec_s1  = 1'b1;
                dec_s2  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_u;
            end
            is_load: begin
                dec_ok  = (funct3 != 3'b011) && (funct3 != 3'b110)
                       && (funct3 != 3'b111);
                dec_s2  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
            end
            is_store: begin
                dec_ok  = (funct3[2] == 1'b0) && (funct3 != 3'b011);
                dec_s2  = 1'b1;
                dec_imm = imm_s;
            end
            is_br: begin
                dec_ok  = (funct3[2:1] != 2'b01);
                dec_br  = 1'b1;
                dec_imm = imm_b;
                if (!funct3[2]) begin
                    dec_alu = `ALU_SUB;
                end else if (!funct3[1]) begin
                    dec_alu = `ALU_SLT;
                end else begin
                    dec_alu = `ALU_SLTU;
                end
            end
            is_jal: begin
                dec_ok  = 1'b1;
                dec_s1  = 1'b1;
                dec_s2  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_j;
            end
            is_jalr: begin
                dec_ok  = (funct3 == 3'b000);
                dec_s2  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = imm_i;
            end
            default: begin
                dec_ok = 1'b0;
            end
        endcase
    end

    // Pack the bundle; undecodable words collapse to a NOP.
    always_comb begin
        dec_b           = '0;
        dec_b.alu_op    = dec_alu;
        dec_b.src1_sel  = dec_s1;
        dec_b.src2_sel  = dec_s2;
        dec_b.imm       = dec_imm;
        dec_b.rs1       = instr[19:15];
        dec_b.rs2       = instr[24:20];
        dec_b.rd        = instr[11:7];
        dec_b.reg_write = dec_wr && (instr[11:7] != 5'd0);
        dec_b.is_branch = dec_br;
        dec_b.illegal   = 1'b0;
        dec_b.pc        = pc;
        if (!dec_ok) begin
            dec_b.alu_op    = `ALU_ADD;
            dec_b.src1_sel  = 1'b0;
            dec_b.src2_sel  = 1'b0;
            dec_b.imm       = '0;
            dec_b.reg_write = 1'b0;
            dec_b.is_branch = 1'b0;
            dec_b.illegal   = ILL_FLAG;
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Slot control: flush beats load, load beats drain.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d  = 1'b1;
            bundle_d = dec_b;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= reset_bundle();
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid = valid_q;
    assign alu_op    = bundle_q.alu_op;
    assign src1_sel  = bundle_q.src1_sel;
    assign src2_sel  = bundle_q.src2_sel;
    assign imm       = bundle_q.imm;
    assign rs1       = bundle_q.rs1;
    assign rs2       = bundle_q.rs2;
    assign rd        = bundle_q.rd;
    assign reg_write = bundle_q.reg_write;
    assign is_branch = bundle_q.is_branch;
    assign illegal   = bundle_q.illegal;
    assign pc_out    = bundle_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors against a reference decode model.
// Honours DECODE_ILLEGAL_EN for the expected illegal flag.
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif
`ifndef ALU_OP_BITS
`define ALU_OP_BITS 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SHL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SHR  4'd6
`define ALU_SHA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_SRC2 4'd10
`endif

module tb_decode_stage;
    localparam int W = `DWORD_BITS;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [`ALU_OP_BITS-1:0] alu;
        logic                    s1;
        logic                    s2;
        logic [W-1:0]            imm;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic                    rw;
        logic                    br;
        logic                    ill;
        logic [W-1:0]            pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [W-1:0] pc;
    logic in_ready, out_valid;
    logic [`ALU_OP_BITS-1:0] alu_op;
    logic src1_sel, src2_sel, reg_write, is_branch, illegal;
    logic [W-1:0] imm, pc_out;
    logic [4:0] rs1, rs2, rd;

    int total = 0;
    int bad = 0;
    int pat_n = 0;

    logic [`ALU_OP_BITS-1:0] f3map [8] = '{`ALU_ADD, `ALU_SHL, `ALU_SLT,
        `ALU_SLTU, `ALU_XOR, `ALU_SHR, `ALU_OR, `ALU_AND};

    logic [31:0] vecs [23] = '{
        32'h00412183, 32'h00001217, 32'h000280E7, 32'h0020E463,
        32'h007372B3, 32'h00311093, 32'h0020A1B3, 32'h0030B193,
        32'h02208133, 32'h00002063, 32'h40311093, 32'h00100013,
        32'h0000000F, 32'hFFF0C093, 32'h4020D093, 32'h0020C263,
        32'h00209023, 32'h00004083, 32'h00003083, 32'h00007023,
        32'h80000537, 32'hFE1FF06F, 32'h00001067};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .src1_sel(src1_sel), .src2_sel(src2_sel),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .is_branch(is_branch),
        .illegal(illegal), .pc_out(pc_out)
    );

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Instruction semantics written from the ISA field layout.
    function automatic exp_t ref_dec(input logic [31:0] w,
                                     input logic [W-1:0] a);
        exp_t e;
        longint sw, v;
        bit ok;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        sw = longint'($signed(w));
        v = sw >>> 31;
        e = '0;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd = w[11:7];
        e.pc = a;
        e.alu = `ALU_ADD;
        ok = 0;
        if (op == 7'h33) begin
            e.rw = 1;
            if (f7 == 0) begin
                ok = 1;
                e.alu = f3map[f3];
            end else if (f7 == 7'h20 && f3 == 0) begin
                ok = 1;
                e.alu = `ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 5) begin
                ok = 1;
                e.alu = `ALU_SHA;
            end
        end else if (op == 7'h13) begin
            e.s2 = 1;
            e.rw = 1;
            e.imm = sw >>> 20;
            e.alu = f3map[f3];
            ok = 1;
            if (f3 == 1 || f3 == 5) begin
                e.imm = longint'(w[24:20]);
                ok = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
                if (f7 == 7'h20) e.alu = `ALU_SHA;
            end
        end else if (op == 7'h37) begin
            ok = 1;
            e.alu = `ALU_SRC2;
            e.s2 = 1;
            e.rw = 1;
            e.imm = (sw >>> 12) << 12;
        end else if (op == 7'h17) begin
            ok = 1;
            e.s1 = 1;
            e.s2 = 1;
            e.rw = 1;
            e.imm = (sw >>> 12) << 12;
        end else if (op == 7'h03) begin
            ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.s2 = 1;
            e.rw = 1;
            e.imm = sw >>> 20;
        end else if (op == 7'h23) begin
            ok = (f3 <= 2);
            e.s2 = 1;
            e.imm = ((sw >>> 25) << 5) | longint'(w[11:7]);
        end else if (op == 7'h63) begin
            ok = (f3 != 2 && f3 != 3);
            e.br = 1;
            e.alu = (f3 < 4) ? `ALU_SUB : (f3 < 6) ? `ALU_SLT : `ALU_SLTU;
            e.imm = (v << 12) | (longint'(w[7]) << 11)
                  | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        end else if (op == 7'h6F) begin
            ok = 1;
            e.s1 = 1;
            e.s2 = 1;
            e.rw = 1;
            e.imm = (v << 20) | (longint'(w[19:12]) << 12)
                  | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        end else if (op == 7'h67) begin
            ok = (f3 == 0);
            e.s2 = 1;
            e.rw = 1;
            e.imm = sw >>> 20;
        end
        if (!ok) begin
            e.alu = `ALU_ADD;
            e.s1 = 0;
            e.s2 = 0;
            e.imm = '0;
            e.rw = 0;
            e.br = 0;
            e.ill = ILL_EXP;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    bit   chk_on = 0;
    bit   m_valid = 0;
    bit   m_fresh = 0;
    exp_t m_e;

    // Reference slot: one-entry queue with flush and reset.
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 0;
            m_fresh <= 1;
            m_e <= '0;
            chk_on <= 1;
        end else if (flush) begin
            m_valid <= 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1;
            m_fresh <= 0;
            m_e <= ref_dec(instr, pc);
        end else if (out_ready) begin
            m_valid <= 0;
        end
    end

    // Per-cycle compare against the reference slot.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", in_ready, !m_valid || out_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid || m_fresh) begin
                chk("alu_op", alu_op, m_e.alu);
                chk("src1_sel", src1_sel, m_e.s1);
                chk("src2_sel", src2_sel, m_e.s2);
                chk("imm", imm, m_e.imm);
                chk("rs1", rs1, m_e.rs1);
                chk("rs2", rs2, m_e.rs2);
                chk("rd", rd, m_e.rd);
                chk("reg_write", reg_write, m_e.rw);
                chk("is_branch", is_branch, m_e.br);
                chk("illegal", illegal, m_e.ill);
                chk("pc_out", pc_out, m_e.pc);
            end
        end
    end

    task automatic push(input logic [31:0] w, input logic [W-1:0] a,
                        input bit pat);
        int n;
        bit acc;
        n = 0;
        instr = w;
        pc = a;
        in_valid = 1;
        forever begin
            if (pat) begin
                out_ready = (pat_n % 3) != 1;
                pat_n++;
            end
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 20) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        flush = 0;
        in_valid = 1;
        instr = 32'h00500093;
        pc = 64'h10;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu", alu_op, `ALU_ADD);
        chk("rst_imm", imm, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_rw", reg_write, 0);
        rst = 0;
        in_valid = 0;

        out_ready = 1;
        push(32'h00500093, 64'h1000, 0);
        chk("addi_valid", out_valid, 1);
        chk("addi_alu", alu_op, `ALU_ADD);
        chk("addi_imm", imm, 5);
        chk("addi_src2", src2_sel, 1);
        chk("addi_rd", rd, 1);
        chk("addi_rw", reg_write, 1);
        chk("addi_pc", pc_out, 64'h1000);

        push(32'h40208133, 64'h1004, 0);
        chk("sub_alu", alu_op, `ALU_SUB);
        chk("sub_rs1", rs1, 1);
        chk("sub_rs2", rs2, 2);
        chk("sub_rd", rd, 2);
        chk("sub_src2", src2_sel, 0);

        push(32'h4041D193, 64'h1008, 0);
        chk("srai_alu", alu_op, `ALU_SHA);
        chk("srai_imm", imm, 4);

        push(32'h123452B7, 64'h100C, 0);
        chk("lui_alu", alu_op, `ALU_SRC2);
        chk("lui_imm", imm, 64'h12345000);
        chk("lui_rd", rd, 5);
        chk("lui_rw", reg_write, 1);

        push(32'hFE000EE3, 64'h1010, 0);
        chk("beq_alu", alu_op, `ALU_SUB);
        chk("beq_br", is_branch, 1);
        chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rw", reg_write, 0);

        push(32'h008000EF, 64'h1014, 0);
        chk("jal_imm", imm, 8);
        chk("jal_src1", src1_sel, 1);

        push(32'hFE20AC23, 64'h1018, 0);
        chk("sw_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("sw_rw", reg_write, 0);
        chk("sw_src2", src2_sel, 1);

        out_ready = 0;
        in_valid = 1;
        instr = 32'h00412183;
        pc = 64'h2000;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_rd", rd, 24);
            chk("stall_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("nobubble_valid", out_valid, 1);
        chk("nobubble_rd", rd, 3);
        chk("nobubble_pc", pc_out, 64'h2000);

        out_ready = 0;
        instr = 32'h00500093;
        pc = 64'h3000;
        flush = 1;
        @(posedge clk);
        #1;
        chk("flush_valid", out_valid, 0);
        flush = 0;
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("flush_drop", out_valid, 0);

        out_ready = 1;
        push(32'hFFFFFFFF, 64'h3004, 0);
        chk("ill_flag", illegal, ILL_EXP);
        chk("ill_alu", alu_op, `ALU_ADD);
        chk("ill_rw", reg_write, 0);

        for (int i = 0; i < 23; i++) begin
            push(vecs[i], 64'hFFFF_FFFF_0000_4000 + 64'(i * 4), 1);
        end
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;

        push(32'h00500093, 64'h5000, 0);
        out_ready = 0;
        in_valid = 1;
        instr = 32'h40208133;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_ready", in_ready, 1);
        rst = 0;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
